// File: rtl/fetch_pc_predictor.sv
// IF-stage PC register with a direct-mapped BTB and 2-bit bimodal counters.
// Ports: clk, rst_n (sync, active-low); pc_en stall; modify_pc_ex/ex_correct_pc
// redirect; ex_update_valid/ex_pc/ex_is_jump/ex_taken/ex_target resolve
// bundle; if_pc/if_pred_taken/if_pred_target/if_btb_hit fetch-side outputs.
module fetch_pc_predictor #(
    parameter int              XLEN        = 32,
    parameter int              BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_en,
    input  logic            modify_pc_ex,
    input  logic [XLEN-1:0] ex_correct_pc,
    input  logic            ex_update_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_is_jump,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    output logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    output logic [XLEN-1:0] if_pred_target,
    output logic            if_btb_hit
);

    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;

    logic            valid_q  [BTB_ENTRIES];
    logic [1:0]      ctr_q    [BTB_ENTRIES];
    logic            jump_q   [BTB_ENTRIES];
    logic [TAGW-1:0] tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0] target_q [BTB_ENTRIES];

    logic [IDX-1:0]  rd_idx;
    logic [TAGW-1:0] rd_tag;
    logic [IDX-1:0]  ex_idx;
    logic [TAGW-1:0] ex_tag;
    logic            ex_hit;
    logic [1:0]      ex_ctr;
    logic [1:0]      ctr_inc;
    logic [1:0]      ctr_dec;

    // Shifts-then-truncate keep pc[1:0] out of both index and tag.
    assign rd_idx = IDX'(if_pc >> 2);
    assign rd_tag = TAGW'(if_pc >> (IDX + 2));
    assign ex_idx = IDX'(ex_pc >> 2);
    assign ex_tag = TAGW'(ex_pc >> (IDX + 2));

    // Lookup works only from registered state: no EX-to-output path.
    assign if_btb_hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign if_pred_taken  = if_btb_hit && (jump_q[rd_idx] || ctr_q[rd_idx][1]);
    assign if_pred_target = if_pred_taken ? target_q[rd_idx]
                                          : if_pc + XLEN'(4);

    assign ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign ex_ctr  = ctr_q[ex_idx];
    assign ctr_inc = (ex_ctr == 2'b11) ? 2'b11 : ex_ctr + 2'd1;
    assign ctr_dec = (ex_ctr == 2'b00) ? 2'b00 : ex_ctr - 2'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_pc <= RESET_PC;
        end else if (modify_pc_ex) begin
            if_pc <= ex_correct_pc;
        end else if (pc_en) begin
            if_pc <= if_pred_target;
        end
    end

    // Valid and counter state: cleared to invalid / weakly not-taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (ex_update_valid) begin
            if (ex_hit) begin
                ctr_q[ex_idx] <= ex_taken ? ctr_inc : ctr_dec;
            end else if (ex_taken) begin
                valid_q[ex_idx] <= 1'b1;
                ctr_q[ex_idx]   <= 2'b10;
            end
        end
    end

    // Payload storage: no reset needed, guarded by valid_q.
    // A taken outcome writes tag/target whether hit or allocate;
    // on a hit the tag is rewritten with the same value.
    always_ff @(posedge clk) begin
        if (rst_n && ex_update_valid) begin
            if (ex_taken) begin
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= ex_target;
            end
            if (ex_hit || ex_taken) begin
                jump_q[ex_idx] <= ex_is_jump;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_predictor.sv
// Self-checking bench for fetch_pc_predictor: directed scenarios followed
// by random traffic, all checked against a table-based reference model.
module tb_fetch_pc_predictor;

    localparam int          N    = 16;
    localparam int          IDXB = 4;
    localparam logic [31:0] RPC  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n, pc_en, modify_pc_ex, ex_update_valid;
    logic        ex_is_jump, ex_taken;
    logic [31:0] ex_correct_pc, ex_pc, ex_target;
    logic [31:0] if_pc, if_pred_target;
    logic        if_pred_taken, if_btb_hit;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_pc;
    bit          m_valid [N];
    logic [31:0] m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];
    bit          m_jump  [N];

    always #5 clk = ~clk;

    fetch_pc_predictor #(
        .XLEN(32), .BTB_ENTRIES(N), .RESET_PC(RPC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pc_en(pc_en),
        .modify_pc_ex(modify_pc_ex), .ex_correct_pc(ex_correct_pc),
        .ex_update_valid(ex_update_valid), .ex_pc(ex_pc),
        .ex_is_jump(ex_is_jump), .ex_taken(ex_taken),
        .ex_target(ex_target), .if_pc(if_pc),
        .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
        .if_btb_hit(if_btb_hit)
    );

    task automatic chk(input string t, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%h exp=%h", t, obs, exp);
        end
    endtask

    function automatic int ix(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic logic [31:0] tg(input logic [31:0] pc);
        return pc >> (IDXB + 2);
    endfunction

    // One clock: drive at negedge, compare outputs to model, advance model.
    task automatic cyc(input bit rn, input bit en, input bit md,
                       input logic [31:0] cpc, input bit uv,
                       input logic [31:0] epc, input bit jp,
                       input bit tk, input logic [31:0] et);
        int          i, j;
        bit          hit, ptk, eh;
        logic [31:0] ptg;
        rst_n = rn; pc_en = en; modify_pc_ex = md; ex_correct_pc = cpc;
        ex_update_valid = uv; ex_pc = epc; ex_is_jump = jp;
        ex_taken = tk; ex_target = et;
        i   = ix(m_pc);
        hit = m_valid[i] && (m_tag[i] == tg(m_pc));
        ptk = hit && (m_jump[i] || m_ctr[i] >= 2);
        ptg = ptk ? m_tgt[i] : m_pc + 32'd4;
        if (chk_en) begin
            chk("pc", if_pc, m_pc);
            chk("hit", {31'b0, if_btb_hit}, {31'b0, hit});
            chk("taken", {31'b0, if_pred_taken}, {31'b0, ptk});
            chk("target", if_pred_target, ptg);
        end
        if (!rn) begin
            m_pc = RPC;
            for (int k = 0; k < N; k++) begin
                m_valid[k] = 1'b0;
                m_ctr[k]   = 1;
            end
        end else begin
            m_pc = md ? cpc : (en ? ptg : m_pc);
            if (uv) begin
                j  = ix(epc);
                eh = m_valid[j] && (m_tag[j] == tg(epc));
                if (eh) begin
                    if (tk) begin
                        m_ctr[j] = (m_ctr[j] == 3) ? 3 : m_ctr[j] + 1;
                        m_tgt[j] = et;
                    end else begin
                        m_ctr[j] = (m_ctr[j] == 0) ? 0 : m_ctr[j] - 1;
                    end
                    m_jump[j] = jp;
                end else if (tk) begin
                    m_valid[j] = 1'b1;
                    m_tag[j]   = tg(epc);
                    m_tgt[j]   = et;
                    m_jump[j]  = jp;
                    m_ctr[j]   = 2;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic redir(input logic [31:0] pc);
        cyc(1, 0, 1, pc, 0, 0, 0, 0, 0);
    endtask

    task automatic upd(input logic [31:0] pc, input bit tk, input bit jp,
                       input logic [31:0] et);
        cyc(1, 0, 0, 0, 1, pc, jp, tk, et);
    endtask

    initial begin
        rst_n = 1'b0; pc_en = 1'b0; modify_pc_ex = 1'b0;
        ex_correct_pc = '0; ex_update_valid = 1'b0; ex_pc = '0;
        ex_is_jump = 1'b0; ex_taken = 1'b0; ex_target = '0;
        m_pc = RPC;
        @(negedge clk);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_pc", if_pc, 32'h100);
        chk("rst_hit", {31'b0, if_btb_hit}, 32'd0);
        chk("rst_taken", {31'b0, if_pred_taken}, 32'd0);
        chk("rst_target", if_pred_target, 32'h104);

        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("step1", if_pc, 32'h104);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("step2", if_pc, 32'h108);

        redir(32'h20);
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("stall", if_pc, 32'h20);
        redir(32'h400);
        chk("stall_redir", if_pc, 32'h400);

        upd(32'h40, 1, 0, 32'h80);
        redir(32'h40);
        chk("alloc_hit", {31'b0, if_btb_hit}, 32'd1);
        chk("alloc_taken", {31'b0, if_pred_taken}, 32'd1);
        chk("alloc_target", if_pred_target, 32'h80);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("follow_target", if_pc, 32'h80);

        redir(32'h40);
        upd(32'h40, 0, 0, 0);
        chk("hyst_nt", {31'b0, if_pred_taken}, 32'd0);
        chk("hyst_nt_tgt", if_pred_target, 32'h44);
        upd(32'h40, 1, 0, 32'h80);
        upd(32'h40, 1, 0, 32'h80);
        chk("hyst_11", {31'b0, if_pred_taken}, 32'd1);
        upd(32'h40, 1, 0, 32'h80);
        repeat (4) upd(32'h40, 0, 0, 0);
        chk("hyst_00", {31'b0, if_pred_taken}, 32'd0);
        upd(32'h40, 0, 0, 0);
        upd(32'h40, 1, 0, 32'h80);
        chk("sat_low", {31'b0, if_pred_taken}, 32'd0);

        upd(32'h440, 1, 1, 32'h1000);
        chk("alias_miss", {31'b0, if_btb_hit}, 32'd0);
        redir(32'h440);
        chk("jump_taken", {31'b0, if_pred_taken}, 32'd1);
        chk("jump_target", if_pred_target, 32'h1000);
        upd(32'h440, 0, 1, 0);
        upd(32'h440, 0, 1, 0);
        chk("jump_low_ctr", {31'b0, if_pred_taken}, 32'd1);

        redir(32'h40);
        upd(32'h40, 1, 0, 32'h200);
        chk("rbw_new", if_pred_target, 32'h200);

        redir(32'hFFFF_FFFC);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("wrap", if_pc, 32'h0);

        cyc(0, 1, 1, 32'h400, 1, 32'h40, 0, 1, 32'h300);
        chk("rst_mid_pc", if_pc, 32'h100);
        redir(32'h40);
        chk("rst_mid_inv", {31'b0, if_btb_hit}, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 99) != 0,
                ($urandom % 4) != 0,
                ($urandom % 6) == 0,
                $urandom & 32'hFC,
                ($urandom % 2) == 1,
                $urandom & 32'hFF,
                ($urandom % 4) == 0,
                ($urandom % 2) == 1,
                $urandom & 32'hFC);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
